// File: rtl/snitch_icache_lookup_arbiter_pkg.sv
// Shared types for the icache lookup arbiter: flush FSM states and the
// derived response-ID width (request ID extended by the port index).
package snitch_icache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } flush_state_e;

  function automatic int unsigned out_id_width(int unsigned in_id_w, int unsigned nr_ports);
    return in_id_w + $clog2(nr_ports);
  endfunction

endpackage

// File: rtl/snitch_icache_lookup_arbiter_if.sv
// Arbiter <-> serial lookup link: request, response ID/handshake and flush.
interface snitch_icache_lookup_arbiter_if #(
  parameter int unsigned FETCH_AW     = 48,
  parameter int unsigned OUT_ID_WIDTH = 4
);
  logic [FETCH_AW-1:0]     lookup_addr;
  logic [OUT_ID_WIDTH-1:0] lookup_id;
  logic                    lookup_valid;
  logic                    lookup_ready;
  logic [OUT_ID_WIDTH-1:0] rsp_id;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic                    flush_valid;
  logic                    flush_ready;

  modport master (
    output lookup_addr, lookup_id, lookup_valid, rsp_ready, flush_valid,
    input  lookup_ready, rsp_id, rsp_valid, flush_ready
  );

  modport slave (
    input  lookup_addr, lookup_id, lookup_valid, rsp_ready, flush_valid,
    output lookup_ready, rsp_id, rsp_valid, flush_ready
  );
endinterface

// File: rtl/snitch_icache_lookup_arbiter_chk.sv
// Non-synthesis checks for the lookup arbiter.
module snitch_icache_lookup_arbiter_chk (
  input logic clk_i,
  input logic rst_i,
  input logic rsp_hs_i,
  input logic cnt_zero_i
);
  no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !(rsp_hs_i && cnt_zero_i))
    else $error("lookup response accepted with no lookup outstanding");
endmodule

// File: rtl/snitch_icache_lookup_arbiter_rr_arb_tree.sv
// Round-robin arbiter with grant lock: once req_o is raised it holds its
// index until gnt_i, so a stalled grant can never be stolen.
module rr_arb_tree #(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned DataWidth = 32,
  parameter bit          LockIn    = 1'b1,
  parameter bit          ExtPrio   = 1'b0,
  parameter bit          AxiVldRdy = 1'b1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumIn-1:0]                  req_i,
  output logic [NumIn-1:0]                  gnt_o,
  input  logic [NumIn-1:0][DataWidth-1:0]   data_i,
  output logic                              req_o,
  input  logic                              gnt_i,
  output logic [DataWidth-1:0]              data_o,
  output logic [$clog2(NumIn)-1:0]          idx_o
);
  localparam int unsigned IdxW         = $clog2(NumIn);
  localparam bit          HoldGrant    = LockIn && AxiVldRdy;
  localparam bit          InternalPrio = !ExtPrio;

  logic [IdxW-1:0] rr_q, lock_idx_q, sel_idx;
  logic            lock_q;

  function automatic logic [IdxW-1:0] wrap_add(logic [IdxW-1:0] base, int unsigned off);
    return IdxW'((int'(base) + int'(off)) % int'(NumIn));
  endfunction

  // Scan downwards so the requester closest to the pointer is assigned last.
  always_comb begin
    sel_idx = rr_q;
    for (int unsigned i = NumIn; i > 0; i--) begin
      sel_idx = req_i[wrap_add(rr_q, i - 1)] ? wrap_add(rr_q, i - 1) : sel_idx;
    end
    if (lock_q) begin
      idx_o = lock_idx_q;
    end else begin
      idx_o = sel_idx;
    end
    req_o  = lock_q | (|req_i);
    data_o = data_i[idx_o];
    for (int unsigned i = 0; i < NumIn; i++) begin
      gnt_o[i] = gnt_i & req_o & (idx_o == IdxW'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= IdxW'(0);
      lock_q     <= 1'b0;
      lock_idx_q <= IdxW'(0);
    end else begin
      lock_q     <= HoldGrant & req_o & ~gnt_i;
      lock_idx_q <= idx_o;
      if (InternalPrio && req_o && gnt_i) begin
        rr_q <= (idx_o == IdxW'(NumIn - 1)) ? IdxW'(0) : idx_o + IdxW'(1);
      end
    end
  end
endmodule

// File: rtl/snitch_icache_lookup_arbiter.sv
// Arbitrates per-port fetch lookups onto one serial lookup, routes responses
// back by the port field of the ID, and sequences drain-then-flush requests.
module snitch_icache_lookup_arbiter
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_PORTS        = 4,
  parameter int unsigned FETCH_AW        = 48,
  parameter int unsigned IN_ID_WIDTH     = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned PortW          = $clog2(NR_PORTS),
  localparam int unsigned OUT_ID_WIDTH   = out_id_width(IN_ID_WIDTH, NR_PORTS)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NR_PORTS-1:0][FETCH_AW-1:0]    in_addr_i,
  input  logic [NR_PORTS-1:0][IN_ID_WIDTH-1:0] in_id_i,
  input  logic [NR_PORTS-1:0]                  in_valid_i,
  output logic [NR_PORTS-1:0]                  in_ready_o,
  output logic [NR_PORTS-1:0][IN_ID_WIDTH-1:0] out_id_o,
  output logic [NR_PORTS-1:0]                  out_valid_o,
  input  logic [NR_PORTS-1:0]                  out_ready_i,
  input  logic                                 flush_valid_i,
  output logic                                 flush_ready_o,
  snitch_icache_lookup_arbiter_if.master       lkp
);
  localparam int unsigned DataW = FETCH_AW + IN_ID_WIDTH;
  localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING + 1);

  flush_state_e                       state_q;
  logic                               flush_valid_q;
  logic [CntW-1:0]                    cnt_q, cnt_d;
  logic [NR_PORTS-1:0][DataW-1:0]     arb_data;
  logic [DataW-1:0]                   arb_out;
  logic [PortW-1:0]                   arb_idx;
  logic [PortW-1:0]                   rsp_port;
  logic                               allow_new, lookup_hs, rsp_hs, rsp_ready;

  // A fresh grant needs an idle FSM, no flush arriving and a free slot.
  assign allow_new = (state_q == IDLE) & ~flush_valid_i & (cnt_q != CntW'(MAX_OUTSTANDING));

  always_comb begin
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      arb_data[p] = {in_addr_i[p], in_id_i[p]};
    end
  end

  rr_arb_tree #(
    .NumIn     (NR_PORTS),
    .DataWidth (DataW),
    .LockIn    (1'b1),
    .ExtPrio   (1'b0),
    .AxiVldRdy (1'b1)
  ) i_rr_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (in_valid_i & {NR_PORTS{allow_new}}),
    .gnt_o  (in_ready_o),
    .data_i (arb_data),
    .req_o  (lkp.lookup_valid),
    .gnt_i  (lkp.lookup_ready),
    .data_o (arb_out),
    .idx_o  (arb_idx)
  );

  assign lkp.lookup_addr = arb_out[DataW-1 -: FETCH_AW];
  assign lkp.lookup_id   = {arb_idx, arb_out[IN_ID_WIDTH-1:0]};

  always_comb begin
    rsp_port    = lkp.rsp_id[OUT_ID_WIDTH-1 -: PortW];
    rsp_ready   = 1'b0;
    out_valid_o = '0;
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      out_id_o[p] = lkp.rsp_id[IN_ID_WIDTH-1:0];
      if (rsp_port == PortW'(p)) begin
        out_valid_o[p] = lkp.rsp_valid;
        rsp_ready      = out_ready_i[p];
      end else begin
        out_valid_o[p] = 1'b0;
      end
    end
  end

  assign lkp.rsp_ready = rsp_ready;
  assign lookup_hs     = lkp.lookup_valid & lkp.lookup_ready;
  assign rsp_hs        = lkp.rsp_valid & rsp_ready;

  always_comb begin
    case ({lookup_hs, rsp_hs})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Drain waits for both the in-flight count and any locked grant to clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      flush_valid_q <= 1'b0;
      cnt_q         <= CntW'(0);
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: if (flush_valid_i) state_q <= DRAIN;
        DRAIN: begin
          if (cnt_q == CntW'(0) && !lkp.lookup_valid) begin
            state_q       <= FLUSH;
            flush_valid_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (lkp.flush_ready) begin
            state_q       <= IDLE;
            flush_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          flush_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign lkp.flush_valid = flush_valid_q;
  assign flush_ready_o   = (state_q == FLUSH) & lkp.flush_ready & ~rst_i;

`ifndef SYNTHESIS
  snitch_icache_lookup_arbiter_chk i_chk (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rsp_hs_i   (rsp_hs),
    .cnt_zero_i (cnt_q == CntW'(0))
  );
`endif
endmodule

// File: tb/tb_snitch_icache_lookup_arbiter.sv
// Directed bench for snitch_icache_lookup_arbiter with default parameters.
module tb_snitch_icache_lookup_arbiter;
  import snitch_icache_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0][47:0]  in_addr;
  logic [3:0][1:0]   in_id;
  logic [3:0]        in_valid, in_ready, out_valid, out_ready;
  logic [3:0][1:0]   out_id;
  logic              flush_valid_i, flush_ready_o;
  int                total = 0;
  int                bad   = 0;
  // Response/lookup IDs per port: {port, 3-port}
  logic [3:0]        exp_lid [4] = '{4'h3, 4'h6, 4'h9, 4'hC};

  always #5 clk = ~clk;

  snitch_icache_lookup_arbiter_if #(.FETCH_AW(48), .OUT_ID_WIDTH(4)) lkp ();

  snitch_icache_lookup_arbiter dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_addr_i     (in_addr),
    .in_id_i       (in_id),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .out_id_o      (out_id),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .flush_valid_i (flush_valid_i),
    .flush_ready_o (flush_ready_o),
    .lkp           (lkp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'h0; out_ready = 4'hF; flush_valid_i = 1'b0;
    lkp.lookup_ready = 1'b0; lkp.rsp_valid = 1'b0; lkp.rsp_id = 4'h0; lkp.flush_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      in_addr[p] = 48'h1234_5678_0000 + 48'(16 * p);
      in_id[p]   = 2'(3 - p);
    end
    tick(); tick();
    chk("rst_lookup_valid", 64'(lkp.lookup_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_flush_valid", 64'(lkp.flush_valid), 64'd0);
    chk("rst_flush_ready", 64'(flush_ready_o), 64'd0);
    chk("rst_cnt", 64'(dut.cnt_q), 64'd0);
    chk("rst_state", 64'(dut.state_q), 64'(IDLE));
    rst = 1'b0;

    // Round robin with all ports requesting, each grant answered next cycle
    in_valid = 4'hF; lkp.lookup_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      int p, prev;
      p = k % 4; prev = (k + 3) % 4;
      lkp.rsp_valid = (k > 0);
      lkp.rsp_id    = exp_lid[prev];
      #1;
      chk("rr_valid", 64'(lkp.lookup_valid), 64'd1);
      chk("rr_id", 64'(lkp.lookup_id), 64'(exp_lid[p]));
      chk("rr_addr", 64'(lkp.lookup_addr), 64'(48'h1234_5678_0000 + 48'(16 * p)));
      chk("rr_in_ready", 64'(in_ready), 64'(4'h1 << p));
      if (k > 0) begin
        chk("rsp_out_valid", 64'(out_valid), 64'(4'h1 << prev));
        chk("rsp_out_id", 64'(out_id[prev]), 64'(3 - prev));
        chk("rsp_ready", 64'(lkp.rsp_ready), 64'd1);
      end
      tick();
    end
    in_valid = 4'h0; lkp.rsp_valid = 1'b1; lkp.rsp_id = exp_lid[2];
    tick();
    lkp.rsp_valid = 1'b0;
    chk("rr_cnt_end", 64'(dut.cnt_q), 64'd0);

    // Stalled grant on port 2 must not be stolen by port 0 (pointer is 3)
    lkp.lookup_ready = 1'b0; in_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) in_valid = 4'b0101;
      #1;
      chk("lock_valid", 64'(lkp.lookup_valid), 64'd1);
      chk("lock_id", 64'(lkp.lookup_id), 64'(exp_lid[2]));
      chk("lock_addr", 64'(lkp.lookup_addr), 64'(48'h1234_5678_0020));
      chk("lock_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    lkp.lookup_ready = 1'b1; #1;
    chk("lock_hs_ready", 64'(in_ready), 64'(4'b0100));
    tick();
    in_valid = 4'b0001; #1;
    chk("lock_next_id", 64'(lkp.lookup_id), 64'(exp_lid[0]));
    chk("lock_next_ready", 64'(in_ready), 64'(4'b0001));
    tick();
    in_valid = 4'h0; lkp.lookup_ready = 1'b0;
    chk("lock_cnt", 64'(dut.cnt_q), 64'd2);

    // Response routed to a port that is not ready
    lkp.rsp_id = 4'b1101; lkp.rsp_valid = 1'b1; out_ready = 4'b0111; #1;
    chk("route_valid", 64'(out_valid), 64'(4'b1000));
    chk("route_id", 64'(out_id[3]), 64'd1);
    chk("route_ready", 64'(lkp.rsp_ready), 64'd0);
    lkp.rsp_valid = 1'b0; out_ready = 4'hF;

    // Flush with two lookups outstanding; flush beats a simultaneous request
    flush_valid_i = 1'b1; in_valid = 4'b0010; #1;
    chk("fl_no_grant", 64'(lkp.lookup_valid), 64'd0);
    chk("fl_no_ready", 64'(in_ready), 64'd0);
    tick();
    chk("fl_state_drain", 64'(dut.state_q), 64'(DRAIN));
    chk("fl_drain_valid", 64'(lkp.lookup_valid), 64'd0);
    chk("fl_drain_fv", 64'(lkp.flush_valid), 64'd0);
    lkp.rsp_valid = 1'b1; lkp.rsp_id = exp_lid[2]; #1;
    chk("fl_drain_route", 64'(out_valid), 64'(4'b0100));
    tick();
    chk("fl_cnt1", 64'(dut.cnt_q), 64'd1);
    lkp.rsp_id = exp_lid[0];
    tick();
    lkp.rsp_valid = 1'b0;
    chk("fl_cnt0", 64'(dut.cnt_q), 64'd0);
    chk("fl_still_drain", 64'(dut.state_q), 64'(DRAIN));
    tick();
    chk("fl_state_flush", 64'(dut.state_q), 64'(FLUSH));
    chk("fl_flush_valid", 64'(lkp.flush_valid), 64'd1);
    chk("fl_no_ack_yet", 64'(flush_ready_o), 64'd0);
    lkp.flush_ready = 1'b1; #1;
    chk("fl_ack", 64'(flush_ready_o), 64'd1);
    tick();
    lkp.flush_ready = 1'b0; flush_valid_i = 1'b0; in_valid = 4'h0;
    chk("fl_back_idle", 64'(dut.state_q), 64'(IDLE));
    chk("fl_fv_low", 64'(lkp.flush_valid), 64'd0);
    chk("fl_ack_low", 64'(flush_ready_o), 64'd0);

    // Outstanding limit: fifth request waits for a response (pointer is 1)
    in_valid = 4'b0010; lkp.lookup_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("max_valid", 64'(lkp.lookup_valid), 64'd1);
      chk("max_id", 64'(lkp.lookup_id), 64'(exp_lid[1]));
      tick();
    end
    chk("max_cnt4", 64'(dut.cnt_q), 64'd4);
    chk("max_held", 64'(lkp.lookup_valid), 64'd0);
    chk("max_held_ready", 64'(in_ready), 64'd0);
    tick();
    lkp.rsp_valid = 1'b1; lkp.rsp_id = exp_lid[1]; #1;
    chk("max_held_rsp", 64'(lkp.lookup_valid), 64'd0);
    tick();
    lkp.rsp_valid = 1'b0;
    chk("max_cnt3", 64'(dut.cnt_q), 64'd3);
    chk("max_freed", 64'(lkp.lookup_valid), 64'd1);
    chk("max_freed_ready", 64'(in_ready), 64'(4'b0010));
    tick();
    in_valid = 4'h0;
    chk("max_cnt_back4", 64'(dut.cnt_q), 64'd4);

    // Drain four lookups, reach FLUSH, then reset abandons it
    flush_valid_i = 1'b1; lkp.rsp_valid = 1'b1; lkp.rsp_id = exp_lid[1];
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("rf_cnt", 64'(dut.cnt_q), 64'(3 - j));
    end
    lkp.rsp_valid = 1'b0;
    tick();
    chk("rf_state_flush", 64'(dut.state_q), 64'(FLUSH));
    rst = 1'b1; lkp.flush_ready = 1'b1; #1;
    chk("rf_no_ack_in_rst", 64'(flush_ready_o), 64'd0);
    tick();
    chk("rf_fv_low", 64'(lkp.flush_valid), 64'd0);
    chk("rf_ack_low", 64'(flush_ready_o), 64'd0);
    chk("rf_cnt0", 64'(dut.cnt_q), 64'd0);
    chk("rf_state_idle", 64'(dut.state_q), 64'(IDLE));
    rst = 1'b0; lkp.flush_ready = 1'b0; flush_valid_i = 1'b0;

    // Pointer restarts at port 0 after reset
    in_valid = 4'hF; lkp.lookup_ready = 1'b0; #1;
    chk("rf_ptr0_id", 64'(lkp.lookup_id), 64'(exp_lid[0]));
    tick();
    in_valid = 4'h0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/snitch_icache_lookup_arbiter.md
SNITCH_ICACHE_LOOKUP_ARBITER -- requirements
Module: snitch_icache_lookup_arbiter

Interface
REQ-001 SHALL have parameter NR_PORTS, default 4: number of fetch requesters; 2..16.
REQ-002 SHALL have parameter FETCH_AW, default 48: fetch address width.
REQ-003 SHALL have parameter IN_ID_WIDTH, default 2: per-port request ID width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4: limit on lookups in flight; 1..15.
REQ-005 SHALL derive PortW = $clog2(NR_PORTS) and OUT_ID_WIDTH = IN_ID_WIDTH + PortW.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk_i  in  1  clock; all logic on its rising edge.
REQ-008 rst_i  in  1  synchronous active-high reset.
REQ-009 in_addr_i / in_id_i / in_valid_i  in  NR_PORTS x FETCH_AW / NR_PORTS x IN_ID_WIDTH / NR_PORTS  per-port lookup requests.
REQ-010 in_ready_o  out  NR_PORTS  per-port request accept.
REQ-011 lookup_addr_o / lookup_id_o / lookup_valid_o  out  FETCH_AW / OUT_ID_WIDTH / 1  request to the serial lookup.
REQ-012 lookup_ready_i  in  1  serial lookup accepts the request.
REQ-013 rsp_id_i / rsp_valid_i  in  OUT_ID_WIDTH / 1  lookup response ID and valid.
REQ-014 rsp_ready_o  out  1  response accept to the lookup.
REQ-015 out_id_o / out_valid_o  out  NR_PORTS x IN_ID_WIDTH / NR_PORTS  per-port response ID and valid; the response payload is broadcast externally.
REQ-016 out_ready_i  in  NR_PORTS  per-port response accept.
REQ-017 flush_valid_i / flush_ready_o  in / out  1 / 1  flush request and flush acknowledge from the cluster.
REQ-018 flush_valid_o / flush_ready_i  out / in  1 / 1  flush request and acknowledge to the lookup.

Function
REQ-019 Arbitration SHALL be round-robin.
  - Priority pointer resets to 0.
  - After each lookup handshake the pointer becomes (granted port + 1) mod NR_PORTS.
REQ-020 Once lookup_valid_o is high without lookup_ready_i, the grant SHALL stay locked.
  - Address, ID and port are held stable until the handshake.
  - A higher-priority port raising valid SHALL NOT steal the grant.
REQ-021 Only the granted port SHALL see in_ready_o = lookup_ready_i; all other in_ready_o bits SHALL be 0.
REQ-022 lookup_id_o SHALL equal {granted port index, in_id_i of that port}.
REQ-023 Response routing SHALL be purely combinational, zero-latency:
  - out_valid_o[p] = rsp_valid_i when rsp_id_i[OUT_ID_WIDTH-1 -: PortW] == p;
  - out_id_o[p] = rsp_id_i[IN_ID_WIDTH-1:0];
  - rsp_ready_o = out_ready_i of the addressed port.
REQ-024 Outstanding counter SHALL count lookups in flight:
  - +1 on a lookup handshake; -1 on a response handshake; unchanged if both occur in the same cycle.
  - Width is $clog2(MAX_OUTSTANDING+1).
REQ-025 No new grant SHALL start while the counter equals MAX_OUTSTANDING; an already-locked grant still completes.
REQ-026 The flush FSM SHALL have states IDLE, DRAIN, FLUSH.
  - IDLE -> DRAIN on flush_valid_i.
  - DRAIN: no new grants; a locked request completes. DRAIN -> FLUSH when counter == 0 and no locked request.
  - FLUSH: flush_valid_o = 1; on flush_ready_i, flush_ready_o = 1 for that cycle and the state returns to IDLE.
REQ-027 flush_valid_i arriving in the same cycle as a new request SHALL take priority: the FSM enters DRAIN and the unlocked request is not granted.
REQ-028 Responses SHALL keep being routed in DRAIN and FLUSH.
REQ-029 Counter underflow (response with counter 0) is illegal; an assertion SHALL flag it in non-synthesis builds.

Reset
REQ-030 On rst_i high at a clock edge, the block SHALL set:
  - state to IDLE, pointer to 0, counter to 0, grant lock cleared;
  - lookup_valid_o, flush_valid_o, flush_ready_o and all in_ready_o bits to 0 in the following cycle.
REQ-031 Reset mid-lock or mid-flush SHALL abandon the operation; no flush_ready_o pulse SHALL be emitted.

Structure
REQ-032 The FSM state enum and the OUT_ID_WIDTH derivation SHALL live in snitch_icache_pkg.
REQ-033 Arbitration SHALL use one sub-module, common_cells rr_arb_tree, with LockIn = 1, ExtPrio = 0 and AxiVldRdy = 1.

Verification
REQ-034 Ports 0..3 valid every cycle, lookup_ready_i always 1 -> grants in order 0,1,2,3,0; lookup_id_o port field cycles 0..3.
REQ-035 Port 2 valid with lookup_ready_i low for 3 cycles, port 0 raises valid in cycle 2 -> lookup_valid_o/addr/id stay on port 2 until ready; port 0 is granted next.
REQ-036 Five back-to-back requests with no responses, MAX_OUTSTANDING = 4 -> 4 handshakes, fifth held; one response frees the slot and the fifth is granted the next cycle.
REQ-037 rsp_id_i = {2'd3, 2'd1}, rsp_valid_i = 1, out_ready_i[3] = 0 -> out_valid_o[3] = 1, out_id_o[3] = 1, rsp_ready_o = 0.
REQ-038 flush_valid_i with 2 outstanding lookups -> FSM in DRAIN, no grants; after both responses flush_valid_o = 1; flush_ready_i -> one-cycle flush_ready_o, state IDLE.
REQ-039 rst_i asserted during FLUSH -> next cycle flush_valid_o = 0, counter = 0, no flush_ready_o pulse.
